// File: rtl/cadss_bus_pkg.sv
// Shared types for the CADSS snooping bus arbiter.
// Bus opcodes, queued request payload and arbiter FSM states.
package cadss_bus_pkg;

    // Widest request address a queue entry can carry
    localparam int BUS_ADDR_W = 64;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2
    } bus_op_t;

    typedef struct packed {
        bus_op_t                 op;
        logic [BUS_ADDR_W-1:0]   addr;
    } bus_req_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNOOP = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cadss_req_fifo.sv
// Per-channel request queue for the CADSS bus arbiter.
// Power-of-two depth, wrap-bit pointers, no push-through when full.
module cadss_req_fifo
    import cadss_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  bus_req_t din,
    output bus_req_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    bus_req_t       mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Advance read/write pointers on accepted push and pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Store accepted payload at the write slot
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cadss_bus_arbiter.sv
// Round-robin snooping bus arbiter for CADSS cache channels.
// Queues requests, broadcasts one snoop at a time, returns completion.
module cadss_bus_arbiter
    import cadss_bus_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int ADDR_W      = 32,
    parameter  int FIFO_DEPTH  = 4,
    parameter  int TIMEOUT_CYC = 64,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TO_W = ($clog2(TIMEOUT_CYC) > 0) ?
                          $clog2(TIMEOUT_CYC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic [NUM_CH-1:0]             req_valid,
    output logic [NUM_CH-1:0]             req_ready,
    input  logic [NUM_CH-1:0][1:0]        req_type,
    input  logic [NUM_CH-1:0][ADDR_W-1:0] req_addr,
    output logic                          snp_valid,
    output logic [1:0]                    snp_type,
    output logic [ADDR_W-1:0]             snp_addr,
    output logic [CH_W-1:0]               snp_src,
    input  logic [NUM_CH-1:0]             snp_ack,
    input  logic [NUM_CH-1:0]             snp_shared,
    output logic [NUM_CH-1:0]             resp_valid,
    output logic                          resp_shared,
    output logic                          resp_err,
    input  logic [NUM_CH-1:0]             resp_ready,
    output logic                          busy,
    output logic [31:0]                   txn_count
);

    arb_state_t           state_q;
    arb_state_t           state_d;

    bus_req_t             head [NUM_CH];
    logic [NUM_CH-1:0]    q_full;
    logic [NUM_CH-1:0]    q_empty;
    logic [NUM_CH-1:0]    q_pop;

    logic [CH_W-1:0]      rr_q;
    logic [CH_W-1:0]      gnt_idx;
    logic [CH_W-1:0]      cand;
    logic                 gnt_found;

    logic [CH_W-1:0]      src_q;
    bus_op_t              op_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [NUM_CH-1:0]    ack_q;
    logic                 shr_q;
    logic                 err_q;
    logic [TO_W-1:0]      tmo_q;

    logic [NUM_CH-1:0]    src_mask;
    logic [NUM_CH-1:0]    ack_now;
    logic [NUM_CH-1:0]    ack_all;
    logic                 shr_now;
    logic                 snp_done;
    logic                 snp_tmo;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        bus_req_t pkt;
        logic     unused_addr;

        // Widen the channel request into the queue payload format
        always_comb begin
            pkt                  = '0;
            pkt.op               = bus_op_t'(req_type[g]);
            pkt.addr[ADDR_W-1:0] = req_addr[g];
        end

        assign unused_addr  = ^head[g].addr;
        assign req_ready[g] = !q_full[g];

        cadss_req_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst_l),
            .push  (req_valid[g]),
            .pop   (q_pop[g]),
            .din   (pkt),
            .dout  (head[g]),
            .full  (q_full[g]),
            .empty (q_empty[g])
        );
    end

    // Pick the first non-empty queue at or after the round-robin pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = CH_W'((int'(rr_q) + k) % NUM_CH);
            if (!gnt_found && !q_empty[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Snoop completion: every channel except the originator has acked
    always_comb begin
        src_mask = NUM_CH'(1) << src_q;
        ack_now  = snp_ack & ~src_mask;
        ack_all  = ack_q | ack_now;
        shr_now  = |(snp_shared & ack_now);
        snp_done = &(ack_all | src_mask);
        snp_tmo  = (tmo_q == TO_W'(TIMEOUT_CYC - 1)) && !snp_done;
    end

    // Next-state and queue pop decode
    always_comb begin
        state_d = state_q;
        q_pop   = '0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    state_d = ST_SNOOP;
                    q_pop   = NUM_CH'(1) << gnt_idx;
                end
            end
            ST_SNOOP: begin
                if (snp_done || snp_tmo) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready[src_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (rst_l) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Capture granted request, collect acks and run the timeout
    always_ff @(posedge clk) begin
        if (rst_l) begin
            rr_q   <= '0;
            src_q  <= '0;
            op_q   <= BUS_RD;
            addr_q <= '0;
            ack_q  <= '0;
            shr_q  <= 1'b0;
            err_q  <= 1'b0;
            tmo_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        src_q  <= gnt_idx;
                        op_q   <= head[gnt_idx].op;
                        addr_q <= head[gnt_idx].addr[ADDR_W-1:0];
                        rr_q   <= (gnt_idx == CH_W'(NUM_CH - 1)) ?
                                  '0 : gnt_idx + CH_W'(1);
                        ack_q  <= '0;
                        shr_q  <= 1'b0;
                        err_q  <= 1'b0;
                        tmo_q  <= '0;
                    end
                end
                ST_SNOOP: begin
                    ack_q <= ack_all;
                    tmo_q <= tmo_q + TO_W'(1);
                    err_q <= snp_tmo;
                    shr_q <= snp_tmo ? 1'b0 : (shr_q | shr_now);
                end
                default: ;
            endcase
        end
    end

    // Count completion handshakes
    always_ff @(posedge clk) begin
        if (rst_l) begin
            txn_count <= '0;
        end else if (state_q == ST_RESP && resp_ready[src_q]) begin
            txn_count <= txn_count + 32'd1;
        end
    end

    assign snp_valid   = (state_q == ST_SNOOP);
    assign snp_type    = op_q;
    assign snp_addr    = addr_q;
    assign snp_src     = src_q;
    assign resp_valid  = (state_q == ST_RESP) ? src_mask : '0;
    assign resp_shared = (state_q == ST_RESP) && shr_q;
    assign resp_err    = (state_q == ST_RESP) && err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cadss_bus_arbiter.sv
// Directed testbench for cadss_bus_arbiter.
// Four-channel instance plus a single-channel instance.
module tb_cadss_bus_arbiter;

    localparam int TMO = 16;

    logic             clk = 1'b0;
    logic             rst_l;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][1:0]  req_type;
    logic [3:0][31:0] req_addr;
    logic             snp_valid;
    logic [1:0]       snp_type;
    logic [31:0]      snp_addr;
    logic [1:0]       snp_src;
    logic [3:0]       snp_ack;
    logic [3:0]       snp_shared;
    logic [3:0]       resp_valid;
    logic             resp_shared;
    logic             resp_err;
    logic [3:0]       resp_ready;
    logic             busy;
    logic [31:0]      txn_count;

    logic             c1_req_valid;
    logic             c1_req_ready;
    logic [0:0][1:0]  c1_req_type;
    logic [0:0][31:0] c1_req_addr;
    logic             c1_snp_valid;
    logic [1:0]       c1_snp_type;
    logic [31:0]      c1_snp_addr;
    logic             c1_snp_src;
    logic             c1_snp_ack;
    logic             c1_snp_shared;
    logic             c1_resp_valid;
    logic             c1_resp_shared;
    logic             c1_resp_err;
    logic             c1_resp_ready;
    logic             c1_busy;
    logic [31:0]      c1_txn_count;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cadss_bus_arbiter #(
        .NUM_CH(4), .ADDR_W(32), .FIFO_DEPTH(4), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_addr(req_addr),
        .snp_valid(snp_valid), .snp_type(snp_type),
        .snp_addr(snp_addr), .snp_src(snp_src),
        .snp_ack(snp_ack), .snp_shared(snp_shared),
        .resp_valid(resp_valid), .resp_shared(resp_shared),
        .resp_err(resp_err), .resp_ready(resp_ready),
        .busy(busy), .txn_count(txn_count)
    );

    cadss_bus_arbiter #(
        .NUM_CH(1), .ADDR_W(32), .FIFO_DEPTH(2), .TIMEOUT_CYC(8)
    ) dut1 (
        .clk(clk), .rst_l(rst_l),
        .req_valid(c1_req_valid), .req_ready(c1_req_ready),
        .req_type(c1_req_type), .req_addr(c1_req_addr),
        .snp_valid(c1_snp_valid), .snp_type(c1_snp_type),
        .snp_addr(c1_snp_addr), .snp_src(c1_snp_src),
        .snp_ack(c1_snp_ack), .snp_shared(c1_snp_shared),
        .resp_valid(c1_resp_valid), .resp_shared(c1_resp_shared),
        .resp_err(c1_resp_err), .resp_ready(c1_resp_ready),
        .busy(c1_busy), .txn_count(c1_txn_count)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_snoop(input string tag);
        int n = 0;
        while (!snp_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_snp"}, snp_valid, 1);
    endtask

    task automatic serve(input string tag, input int src,
                         input logic [31:0] addr);
        wait_snoop(tag);
        check({tag, "_src"}, snp_src, src);
        check({tag, "_addr"}, snp_addr, addr);
        snp_ack = '1;
        step();
        snp_ack = '0;
        check({tag, "_resp"}, resp_valid, 4'b1 << src);
        resp_ready = '1;
        step();
        resp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_l = 1'b1;
        req_valid = '0; req_type = '0; req_addr = '0;
        snp_ack = '0; snp_shared = '0; resp_ready = '0;
        c1_req_valid = 1'b0; c1_req_type = '0; c1_req_addr = '0;
        c1_snp_ack = 1'b0; c1_snp_shared = 1'b0; c1_resp_ready = 1'b0;
        step();
        step();
        rst_l = 1'b0;

        check("rst_ready", req_ready, 4'hF);
        check("rst_snp", snp_valid, 0);
        check("rst_resp", resp_valid, 0);
        check("rst_shared", resp_shared, 0);
        check("rst_err", resp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_txn", txn_count, 0);

        // single request from ch2, shared copy in ch1
        req_valid = 4'b0100;
        req_type[2] = 2'd0;
        req_addr[2] = 32'h1000;
        step();
        req_valid = '0;
        check("lat_t1_snp", snp_valid, 0);
        step();
        check("lat_t2_snp", snp_valid, 1);
        check("s1_src", snp_src, 2);
        check("s1_addr", snp_addr, 32'h1000);
        check("s1_type", snp_type, 0);
        check("s1_busy", busy, 1);
        step();
        check("s1_stable_snp", snp_valid, 1);
        check("s1_stable_addr", snp_addr, 32'h1000);
        snp_ack = 4'b1011;
        snp_shared = 4'b0010;
        step();
        snp_ack = '0;
        snp_shared = '0;
        check("s1_resp", resp_valid, 4'b0100);
        check("s1_shared", resp_shared, 1);
        check("s1_err", resp_err, 0);
        check("s1_snp_off", snp_valid, 0);
        step();
        check("s1_hold", resp_valid, 4'b0100);
        resp_ready = 4'b0100;
        step();
        resp_ready = '0;
        check("s1_done", resp_valid, 0);
        check("s1_idle", busy, 0);
        check("s1_txn", txn_count, 1);

        // reset during snoop drops active and queued work
        req_valid = 4'b0101;
        req_addr[0] = 32'hA000;
        req_addr[2] = 32'hA002;
        step();
        req_valid = '0;
        step();
        check("r_snp", snp_valid, 1);
        check("r_src", snp_src, 0);
        rst_l = 1'b1;
        step();
        rst_l = 1'b0;
        check("r_snp_off", snp_valid, 0);
        check("r_busy", busy, 0);
        check("r_ready", req_ready, 4'hF);
        check("r_txn", txn_count, 0);
        step();
        step();
        check("r_dropped_snp", snp_valid, 0);
        check("r_dropped_resp", resp_valid, 0);

        // two simultaneous bursts, each served 0,1,2,3
        for (int b = 0; b < 2; b++) begin
            req_valid = 4'hF;
            for (int i = 0; i < 4; i++)
                req_addr[i] = 32'h100 * (b + 1) + i;
            step();
            req_valid = '0;
            for (int i = 0; i < 4; i++)
                serve($sformatf("b%0d_ch%0d", b, i), i,
                      32'h100 * (b + 1) + i);
        end
        check("b_txn", txn_count, 8);

        // ch0 fills its queue while ch1 holds the bus in RESP
        req_valid = 4'b0010;
        req_addr[1] = 32'h5000;
        step();
        req_valid = '0;
        wait_snoop("f_ch1");
        snp_ack = '1;
        step();
        snp_ack = '0;
        check("f_resp", resp_valid, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            req_valid[0] = 1'b1;
            req_addr[0] = 32'h200 + k;
            step();
            check($sformatf("f_rdy%0d", k), req_ready[0], (k < 3));
        end
        req_addr[0] = 32'h204;
        step();
        check("f_stall", req_ready[0], 0);
        check("f_hold", resp_valid, 4'b0010);
        resp_ready = 4'b0010;
        step();
        resp_ready = '0;
        check("f_still_full", req_ready[0], 0);
        step();
        check("f_popped", req_ready[0], 1);
        check("f_gnt_src", snp_src, 0);
        step();
        req_valid = '0;
        check("f_refull", req_ready[0], 0);
        for (int k = 0; k < 5; k++)
            serve($sformatf("f_q%0d", k), 0, 32'h200 + k);
        check("f_txn", txn_count, 14);

        // sticky acks; acks before snoop entry are discarded
        req_valid = 4'b1000;
        req_addr[3] = 32'h3000;
        snp_ack = '1;
        snp_shared = '1;
        step();
        req_valid = '0;
        step();
        snp_ack = '0;
        snp_shared = '0;
        check("k_snp", snp_valid, 1);
        check("k_src", snp_src, 3);
        snp_ack = 4'b0001;
        step();
        snp_ack = 4'b0100;
        check("k_wait1", snp_valid, 1);
        step();
        snp_ack = 4'b0010;
        snp_shared = 4'b0010;
        check("k_wait2", snp_valid, 1);
        step();
        snp_ack = '0;
        snp_shared = '0;
        check("k_resp", resp_valid, 4'b1000);
        check("k_shared", resp_shared, 1);
        resp_ready = 4'b1000;
        step();
        resp_ready = '0;
        check("k_txn", txn_count, 15);

        // ch3 never acks: abort after TMO snoop cycles
        req_valid = 4'b0010;
        req_type[1] = 2'd2;
        req_addr[1] = 32'h4000;
        step();
        req_valid = '0;
        wait_snoop("t");
        check("t_type", snp_type, 2);
        snp_ack = 4'b0101;
        snp_shared = 4'b0101;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!resp_valid[1] && cnt < 100);
        snp_ack = '0;
        snp_shared = '0;
        check("t_cycles", cnt, TMO);
        check("t_resp", resp_valid, 4'b0010);
        check("t_err", resp_err, 1);
        check("t_shared", resp_shared, 0);
        resp_ready = 4'b0010;
        step();
        resp_ready = '0;
        check("t_txn", txn_count, 16);
        check("t_idle", busy, 0);

        // single-channel instance
        check("c1_rst_ready", c1_req_ready, 1);
        c1_req_valid = 1'b1;
        c1_req_type[0] = 2'd1;
        c1_req_addr[0] = 32'hFFFF_FFFC;
        c1_snp_ack = 1'b1;
        c1_snp_shared = 1'b1;
        step();
        c1_req_valid = 1'b0;
        check("c1_lat1", c1_snp_valid, 0);
        step();
        check("c1_snp", c1_snp_valid, 1);
        check("c1_type", c1_snp_type, 1);
        check("c1_addr", c1_snp_addr, 32'hFFFF_FFFC);
        step();
        check("c1_snp_one", c1_snp_valid, 0);
        check("c1_resp", c1_resp_valid, 1);
        check("c1_shared", c1_resp_shared, 0);
        check("c1_err", c1_resp_err, 0);
        c1_resp_ready = 1'b1;
        step();
        c1_resp_ready = 1'b0;
        c1_snp_ack = 1'b0;
        c1_snp_shared = 1'b0;
        check("c1_txn", c1_txn_count, 1);
        check("c1_idle", c1_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
